// File: rtl/hcsr04_nch_scheduler_pkg.sv
// Shared state type and sizing helpers for the multi-channel HC-SR04 ranging scheduler.
package hcsr04_pkg;

   typedef enum logic [1:0] {
      S_SELECT,
      S_START,
      S_WAIT,
      S_GUARD
   } state_e;

   function automatic int ms_div(input int clk_hz);
      return clk_hz / 1000;
   endfunction

   function automatic int ch_w(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/hcsr04_nch_scheduler_ms_timer.sv
// Clearable millisecond timer: prescaler plus 16-bit ms counter, flags the last cycle of tc_i full ms.
module hcsr04_ms_timer
   import hcsr04_pkg::*;
#(
   parameter int MS_DIV = 50_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_i,
   input  logic [15:0] tc_i,
   output logic        expired_o
);

   localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(MS_DIV - 1);

   logic [PW-1:0] pre_q, pre_d;
   logic [15:0]   ms_q, ms_d;
   logic          preWrap;

   assign preWrap = (pre_q == PRE_LAST);

   // A zero terminal count expires immediately, giving a one-cycle interval.
   assign expired_o = (tc_i == 16'd0) ||
                      (preWrap && (({1'b0, ms_q} + 17'd1) == {1'b0, tc_i}));

   always_comb begin
      pre_d = pre_q;
      ms_d  = ms_q;
      if (clr_i) begin
         pre_d = '0;
         ms_d  = '0;
      end else if (preWrap) begin
         pre_d = '0;
         ms_d  = ms_q + 16'd1;
      end else begin
         pre_d = pre_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
         ms_q  <= '0;
      end else begin
         pre_q <= pre_d;
         ms_q  <= ms_d;
      end
   end

endmodule

// File: rtl/hcsr04_nch_scheduler.sv
// Round-robin HC-SR04 trigger scheduler with guard silence and per-measurement timeout.
// Optional per-channel timeout statistics are built when HCSR04_SCHED_STATS_EN is defined.
module hcsr04_nch_scheduler
   import hcsr04_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int CLK_HZ     = 50_000_000,
   parameter int GUARD_MS   = 10,
   parameter int TIMEOUT_MS = 60,
   localparam int CH_W      = ch_w(NUM_CH)
) (
   input  logic                clk,
   input  logic                rst_n,
`ifdef HCSR04_SCHED_STATS_EN
   input  logic                stats_clr,
   output logic [NUM_CH*8-1:0] timeout_cnt,
`endif
   input  logic [NUM_CH-1:0]   ch_en,
   input  logic [NUM_CH-1:0]   done,
   output logic [NUM_CH-1:0]   start,
   output logic [CH_W-1:0]     active_ch,
   output logic                busy,
   output logic                timeout_pulse,
   output logic [CH_W-1:0]     timeout_ch
);

   localparam int MS_DIV = ms_div(CLK_HZ);

   if (NUM_CH < 1 || NUM_CH > 16) begin : gBadNumCh
      $error("NUM_CH must be in 1..16");
   end
   if (TIMEOUT_MS < 1 || TIMEOUT_MS > 65535) begin : gBadTimeout
      $error("TIMEOUT_MS must be in 1..65535");
   end
   if (GUARD_MS < 0 || GUARD_MS > 65535) begin : gBadGuard
      $error("GUARD_MS must be in 0..65535");
   end
   if (CLK_HZ < 1000) begin : gBadClk
      $error("CLK_HZ must be at least 1000");
   end

   state_e            state_q;
   logic [CH_W-1:0]   ptr_q, activeCh_q, toCh_q;
   logic [NUM_CH-1:0] start_q;
   logic              busy_q, toPulse_q;

   logic [CH_W-1:0]   selCh, scanIdx;
   logic              found, doneAct, expired, timerClr;
   logic [15:0]       tcMs;

   // Search upward from the channel after the last one served.
   always_comb begin
      found   = 1'b0;
      selCh   = '0;
      scanIdx = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         scanIdx = CH_W'((int'(ptr_q) + i) % NUM_CH);
         if (!found && ch_en[scanIdx]) begin
            found = 1'b1;
            selCh = scanIdx;
         end
      end
   end

   assign doneAct  = done[activeCh_q];
   assign tcMs     = (state_q == S_WAIT) ? 16'(TIMEOUT_MS) : 16'(GUARD_MS);
   assign timerClr = !(state_q == S_WAIT || state_q == S_GUARD) || expired ||
                     (state_q == S_WAIT && doneAct);

   hcsr04_ms_timer #(.MS_DIV(MS_DIV)) uTimer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (timerClr),
      .tc_i      (tcMs),
      .expired_o (expired)
   );

   // Done takes priority over timer expiry in the same WAIT cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_SELECT;
         ptr_q      <= CH_W'(NUM_CH - 1);
         activeCh_q <= '0;
         start_q    <= '0;
         busy_q     <= 1'b0;
         toPulse_q  <= 1'b0;
         toCh_q     <= '0;
      end else begin
         start_q   <= '0;
         toPulse_q <= 1'b0;
         case (state_q)
            S_SELECT: begin
               if (found) begin
                  activeCh_q <= selCh;
                  ptr_q      <= selCh;
                  start_q    <= NUM_CH'(1) << selCh;
                  busy_q     <= 1'b1;
                  state_q    <= S_START;
               end else begin
                  busy_q <= 1'b0;
               end
            end
            S_START: state_q <= S_WAIT;
            S_WAIT: begin
               if (doneAct) begin
                  state_q <= S_GUARD;
               end else if (expired) begin
                  toPulse_q <= 1'b1;
                  toCh_q    <= activeCh_q;
                  state_q   <= S_GUARD;
               end
            end
            S_GUARD: begin
               if (expired) begin
                  busy_q  <= 1'b0;
                  state_q <= S_SELECT;
               end
            end
            default: state_q <= S_SELECT;
         endcase
      end
   end

   assign start         = start_q;
   assign active_ch     = activeCh_q;
   assign busy          = busy_q;
   assign timeout_pulse = toPulse_q;
   assign timeout_ch    = toCh_q;

`ifdef HCSR04_SCHED_STATS_EN
   logic [7:0] cnt_q [NUM_CH];
   logic       toEvent;

   assign toEvent = (state_q == S_WAIT) && !doneAct && expired;

   // Clear beats a coincident increment; counters stick at 255.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (stats_clr) begin
               cnt_q[k] <= '0;
            end else if (toEvent && activeCh_q == CH_W'(k) && cnt_q[k] != 8'hFF) begin
               cnt_q[k] <= cnt_q[k] + 8'd1;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : gCnt
      assign timeout_cnt[g*8 +: 8] = cnt_q[g];
   end
`endif

endmodule

// File: tb/tb_hcsr04_nch_scheduler.sv
// Directed self-checking bench for the HC-SR04 round-robin scheduler.
`timescale 1ns/1ps
module tb_hcsr04_nch_scheduler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] chEn = 4'b0000;
   logic [3:0] respDone = 4'b0000;
   logic [3:0] manualDone = 4'b0000;
   logic [3:0] doneBus;
   logic [3:0] startBus;
   logic [1:0] activeCh;
   logic       busy;
   logic       timeoutPulse;
   logic [1:0] timeoutCh;

   int total = 0;
   int bad = 0;
   int cycleNo = 0;
   int startCnt = 0, lastStartCh = -1, lastStartCyc = 0, startBits = 0;
   int toCnt = 0, lastToCyc = 0, lastToCh = -1, busyHighCnt = 0;
   int respDelay [4] = '{100, 100, 100, 100};
   int respCnt [4] = '{-1, -1, -1, -1};

   assign doneBus = respDone | manualDone;

`ifdef HCSR04_SCHED_STATS_EN
   logic        statsClr = 1'b0;
   logic        statsClr2 = 1'b0;
   logic [31:0] timeoutCnt;
   logic [7:0]  timeoutCnt2;
   logic [0:0]  start2, activeCh2, timeoutCh2;
   logic        busy2, timeoutPulse2;
   int          to2Cnt = 0;
`endif

   hcsr04_nch_scheduler #(
      .NUM_CH(4), .CLK_HZ(1_000_000), .GUARD_MS(2), .TIMEOUT_MS(5)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
`ifdef HCSR04_SCHED_STATS_EN
      .stats_clr     (statsClr),
      .timeout_cnt   (timeoutCnt),
`endif
      .ch_en         (chEn),
      .done          (doneBus),
      .start         (startBus),
      .active_ch     (activeCh),
      .busy          (busy),
      .timeout_pulse (timeoutPulse),
      .timeout_ch    (timeoutCh)
   );

`ifdef HCSR04_SCHED_STATS_EN
   // Fast single-channel instance that times out every four cycles.
   hcsr04_nch_scheduler #(
      .NUM_CH(1), .CLK_HZ(1000), .GUARD_MS(0), .TIMEOUT_MS(1)
   ) dut2 (
      .clk           (clk),
      .rst_n         (rst_n),
      .stats_clr     (statsClr2),
      .timeout_cnt   (timeoutCnt2),
      .ch_en         (1'b1),
      .done          (1'b0),
      .start         (start2),
      .active_ch     (activeCh2),
      .busy          (busy2),
      .timeout_pulse (timeoutPulse2),
      .timeout_ch    (timeoutCh2)
   );
`endif

   always #5 clk = ~clk;

   always @(posedge clk) cycleNo++;

   // Sensor model: answers respDelay cycles after WAIT entry, negative means never.
   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         respDone[k] = (respCnt[k] == 0);
         if (respCnt[k] >= 0) respCnt[k]--;
         if (startBus[k] && respDelay[k] >= 0) respCnt[k] = respDelay[k];
      end
   end

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      total++;
      if (observed != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] en, input int d0, input int d1,
                                input int d2, input int d3);
      chEn         = en;
      respDelay[0] = d0;
      respDelay[1] = d1;
      respDelay[2] = d2;
      respDelay[3] = d3;
   endtask

   task automatic runCycles(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         if (startBus != 4'b0000) begin
            startCnt++;
            startBits    = $countones(startBus);
            lastStartCyc = cycleNo;
            for (int k = 0; k < 4; k++) if (startBus[k]) lastStartCh = k;
         end
         if (timeoutPulse) begin
            toCnt++;
            lastToCyc = cycleNo;
            lastToCh  = int'(timeoutCh);
         end
         if (busy) busyHighCnt++;
`ifdef HCSR04_SCHED_STATS_EN
         if (timeoutPulse2) to2Cnt++;
`endif
      end
   endtask

   task automatic waitStart(input int budget);
      int base;
      int n;
      base = startCnt;
      n = 0;
      while (startCnt == base && n < budget) begin
         runCycles(1);
         n++;
      end
      if (startCnt == base) lastStartCh = -1;
   endtask

   task automatic waitIdle(input int budget, output int cyc);
      int n;
      n = 0;
      cyc = -1;
      while (n < budget) begin
         runCycles(1);
         n++;
         if (!busy) begin
            cyc = cycleNo;
            break;
         end
      end
   endtask

   initial begin
      int relCyc, prevCyc, s0, s1, idleCyc, toBase, stBase, bzBase;
      int exp2 [4] = '{1, 3, 1, 3};

      #1 rst_n = 1'b0;
      runCycles(3);
      checkOutput("rst start", startBus, 0);
      checkOutput("rst active_ch", activeCh, 0);
      checkOutput("rst busy", busy, 0);
      checkOutput("rst timeout_pulse", timeoutPulse, 0);
      checkOutput("rst timeout_ch", timeoutCh, 0);

      // Full rotation over all four channels.
      applyStimulus(4'b1111, 100, 100, 100, 100);
      relCyc = cycleNo;
      rst_n = 1'b1;
      waitStart(100);
      checkOutput("first start latency", lastStartCyc - relCyc, 1);
      checkOutput("rot0 ch", lastStartCh, 0);
      checkOutput("rot0 onehot", startBits, 1);
      checkOutput("rot0 busy", busy, 1);
      checkOutput("rot0 active_ch", activeCh, 0);
      prevCyc = lastStartCyc;
      for (int i = 1; i <= 4; i++) begin
         waitStart(5000);
         checkOutput($sformatf("rot%0d ch", i), lastStartCh, i % 4);
         checkOutput($sformatf("rot%0d gap", i), lastStartCyc - prevCyc, 2103);
         prevCyc = lastStartCyc;
      end

      // Masked rotation, then an empty mask.
      chEn = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         waitStart(5000);
         checkOutput($sformatf("mask%0d ch", i), lastStartCh, exp2[i]);
         checkOutput($sformatf("mask%0d gap", i), lastStartCyc - prevCyc, 2103);
         prevCyc = lastStartCyc;
      end
      chEn = 4'b0000;
      waitIdle(5000, idleCyc);
      checkOutput("mask idle cycle", idleCyc - prevCyc, 2102);
      stBase = startCnt;
      bzBase = busyHighCnt;
      runCycles(20000);
      checkOutput("idle starts", startCnt - stBase, 0);
      checkOutput("idle busy", busyHighCnt - bzBase, 0);

      // Dead sensor on channel 2.
      applyStimulus(4'b1100, 100, 100, -1, 100);
      toBase = toCnt;
      waitStart(100);
      checkOutput("to ch2 start", lastStartCh, 2);
      s0 = lastStartCyc;
      waitStart(10000);
      checkOutput("to next ch", lastStartCh, 3);
      checkOutput("to next gap", lastStartCyc - s0, 7002);
      checkOutput("to pulses", toCnt - toBase, 1);
      checkOutput("to pulse time", lastToCyc - s0, 5001);
      checkOutput("to pulse ch", lastToCh, 2);
      checkOutput("to ch held", timeoutCh, 2);

      // Races: done at expiry, foreign done, mask cleared mid-measurement.
      prevCyc = lastStartCyc;
      chEn = 4'b0001;
      respDelay[0] = 4999;
      waitStart(5000);
      checkOutput("race ch", lastStartCh, 0);
      checkOutput("race gap", lastStartCyc - prevCyc, 2103);
      s0 = lastStartCyc;
      toBase = toCnt;
      runCycles(50);
      manualDone = 4'b0010;
      respDelay[0] = 100;
      runCycles(1);
      manualDone = 4'b0000;
      waitStart(10000);
      checkOutput("race retrigger ch", lastStartCh, 0);
      checkOutput("race retrigger gap", lastStartCyc - s0, 7002);
      checkOutput("race no timeout", toCnt - toBase, 0);
      s1 = lastStartCyc;
      runCycles(10);
      chEn = 4'b0000;
      waitIdle(5000, idleCyc);
      checkOutput("mask clear completes", idleCyc - s1, 2102);
      checkOutput("mask clear no timeout", toCnt - toBase, 0);

`ifdef HCSR04_SCHED_STATS_EN
      // Two more channel-2 timeouts bring its count to three.
      applyStimulus(4'b0100, 100, 100, -1, 100);
      toBase = toCnt;
      waitStart(100);
      checkOutput("stats ch2 a", lastStartCh, 2);
      waitStart(10000);
      checkOutput("stats ch2 b", lastStartCh, 2);
      chEn = 4'b0000;
      waitIdle(10000, idleCyc);
      checkOutput("stats pulses", toCnt - toBase, 2);
      checkOutput("stats cnt ch2", timeoutCnt[23:16], 3);
      checkOutput("stats cnt ch0", timeoutCnt[7:0], 0);
      checkOutput("stats cnt ch3", timeoutCnt[31:24], 0);
      statsClr = 1'b1;
      runCycles(1);
      statsClr = 1'b0;
      checkOutput("stats clr", timeoutCnt, 0);

      statsClr2 = 1'b1;
      runCycles(1);
      statsClr2 = 1'b0;
      checkOutput("sat clr", timeoutCnt2, 0);
      toBase = to2Cnt;
      for (int n = 0; n < 1000 && (to2Cnt - toBase) < 100; n++) runCycles(1);
      checkOutput("sat pulses 100", to2Cnt - toBase, 100);
      checkOutput("sat cnt 100", timeoutCnt2, 100);
      for (int n = 0; n < 2000 && (to2Cnt - toBase) < 300; n++) runCycles(1);
      checkOutput("sat pulses 300", to2Cnt - toBase, 300);
      checkOutput("sat cnt 300", timeoutCnt2, 255);
`endif

      // Asynchronous reset in the middle of a WAIT on channel 1.
      applyStimulus(4'b0010, 100, -1, 100, 100);
      waitStart(100);
      checkOutput("arst ch1 start", lastStartCh, 1);
      runCycles(100);
      checkOutput("arst busy before", busy, 1);
      checkOutput("arst active before", activeCh, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("arst start", startBus, 0);
      checkOutput("arst busy", busy, 0);
      checkOutput("arst active_ch", activeCh, 0);
      checkOutput("arst timeout_pulse", timeoutPulse, 0);
      checkOutput("arst timeout_ch", timeoutCh, 0);
      applyStimulus(4'b1111, 100, 100, 100, 100);
      runCycles(2);
      relCyc = cycleNo;
      rst_n = 1'b1;
      waitStart(100);
      checkOutput("arst restart ch", lastStartCh, 0);
      checkOutput("arst restart latency", lastStartCyc - relCyc, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
